// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage with frame backpressure,
// mid-frame stalls and self-draining of the final frame's differences.
module r2sdf_stage #(
  parameter int IN_W    = 11,
  parameter int DEPTH   = 16,
  parameter int TW_MODE = 0,
  parameter int SCALE   = 0,
  localparam int OUT_W  = IN_W + 1 - SCALE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic signed [IN_W-1:0]  data_in_r,
  input  logic signed [IN_W-1:0]  data_in_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] data_out_r,
  output logic signed [OUT_W-1:0] data_out_i,
  output logic                    busy_o
);

  // state   | meaning
  // S_IDLE  | fill: store first half of a frame, no output
  // S_BFLY  | second half: emit sums, store (twiddled) differences
  // S_OVL   | emit stored differences while filling the next frame
  // S_DRAIN | no new frame arrived: flush remaining differences, ready_o=0
  typedef enum logic [1:0] {S_IDLE, S_BFLY, S_OVL, S_DRAIN} state_t;

  localparam int KW = $clog2(DEPTH);
  localparam int DW = IN_W + 1;

  state_t                r_state, w_state_nx;
  logic [KW-1:0]         r_k, w_k_nx;
  logic signed [DW-1:0]  r_fifo_r [DEPTH];
  logic signed [DW-1:0]  r_fifo_i [DEPTH];
  logic                  r_valid;
  logic signed [OUT_W-1:0] r_data_r, r_data_i;

  logic                  w_shift, w_out_vld, w_k_last, w_rot;
  logic signed [DW-1:0]  w_head_r, w_head_i, w_x_r, w_x_i;
  logic signed [DW-1:0]  w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic signed [DW-1:0]  w_dtw_r, w_dtw_i, w_wr_r, w_wr_i, w_out_r, w_out_i;
  logic signed [OUT_W-1:0] w_sc_r, w_sc_i;

  assign w_head_r = r_fifo_r[DEPTH-1];
  assign w_head_i = r_fifo_i[DEPTH-1];
  assign w_x_r    = {data_in_r[IN_W-1], data_in_r};
  assign w_x_i    = {data_in_i[IN_W-1], data_in_i};
  assign w_sum_r  = w_head_r + w_x_r;
  assign w_sum_i  = w_head_i + w_x_i;
  assign w_dif_r  = w_head_r - w_x_r;
  assign w_dif_i  = w_head_i - w_x_i;

  // Multiply by -j in the upper half of k; |dif| < 2^IN_W so negation is safe.
  assign w_rot    = (TW_MODE != 0) && r_k[KW-1];
  assign w_dtw_r  = w_rot ? w_dif_i : w_dif_r;
  assign w_dtw_i  = w_rot ? -w_dif_r : w_dif_i;

  assign w_k_last = (r_k == KW'(DEPTH - 1));

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_shift    = 1'b0;
    w_wr_r     = w_x_r;
    w_wr_i     = w_x_i;
    w_out_vld  = 1'b0;
    w_out_r    = w_head_r;
    w_out_i    = w_head_i;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_shift = 1'b1;
          w_k_nx  = r_k + KW'(1);
          if (w_k_last) w_state_nx = S_BFLY;
        end
      end
      S_BFLY: begin
        if (valid_i) begin
          w_shift   = 1'b1;
          w_out_vld = 1'b1;
          w_out_r   = w_sum_r;
          w_out_i   = w_sum_i;
          w_wr_r    = w_dtw_r;
          w_wr_i    = w_dtw_i;
          w_k_nx    = r_k + KW'(1);
          if (w_k_last) w_state_nx = S_OVL;
        end
      end
      S_OVL: begin
        if (valid_i) begin
          w_shift   = 1'b1;
          w_out_vld = 1'b1;
          w_k_nx    = r_k + KW'(1);
          if (w_k_last) w_state_nx = S_BFLY;
        end else if (r_k == '0) begin
          // Frame boundary with no new sample: start flushing on our own.
          w_shift    = 1'b1;
          w_out_vld  = 1'b1;
          w_wr_r     = '0;
          w_wr_i     = '0;
          w_k_nx     = KW'(1);
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_shift   = 1'b1;
        w_out_vld = 1'b1;
        w_wr_r    = '0;
        w_wr_i    = '0;
        w_k_nx    = r_k + KW'(1);
        if (w_k_last) w_state_nx = S_IDLE;
      end
      default: ;
    endcase
  end

  assign w_sc_r = OUT_W'(w_out_r >>> SCALE);
  assign w_sc_i = OUT_W'(w_out_i >>> SCALE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_valid  <= 1'b0;
      r_data_r <= '0;
      r_data_i <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_r[i] <= '0;
        r_fifo_i[i] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_valid <= w_out_vld;
      if (w_out_vld) begin
        r_data_r <= w_sc_r;
        r_data_i <= w_sc_i;
      end
      if (w_shift) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          r_fifo_r[i] <= r_fifo_r[i-1];
          r_fifo_i[i] <= r_fifo_i[i-1];
        end
        r_fifo_r[0] <= w_wr_r;
        r_fifo_i[0] <= w_wr_i;
      end
    end
  end

  assign ready_o    = (r_state != S_DRAIN);
  assign busy_o     = (r_state != S_IDLE);
  assign valid_o    = r_valid;
  assign data_out_r = r_data_r;
  assign data_out_i = r_data_i;

endmodule
